// File: rtl/burst_addr_gen_pkg.sv
// rtl/burst_addr_gen_pkg.sv - shared types and address helpers for the burst address generator
//   Provides: burst_t, state_t, calc_t, align(), page_cross().
package burst_addr_gen_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned CALC_W    = 64;
  localparam int unsigned PAGE_LOG2 = 12;

  // Wide scratch type so the helpers work for any ADDR_W; callers truncate.
  typedef logic [CALC_W-1:0] calc_t;

  function automatic calc_t align(input calc_t addr, input logic [2:0] size);
    calc_t mask;
    mask = (calc_t'(1) << size) - calc_t'(1);
    return addr & ~mask;
  endfunction

  // True when the last byte of an INCR burst falls in another 4 KB page.
  // The end address wraps at aw bits, matching the datapath arithmetic.
  function automatic logic page_cross(input calc_t addr, input calc_t len,
                                      input logic [2:0] size, input int unsigned aw);
    calc_t amask;
    calc_t last;
    if (aw >= CALC_W) amask = '1;
    else              amask = (calc_t'(1) << aw) - calc_t'(1);
    last = (align(addr, size) + ((len + calc_t'(1)) << size) - calc_t'(1)) & amask;
    return (last >> PAGE_LOG2) != ((addr & amask) >> PAGE_LOG2);
  endfunction

endpackage

// File: rtl/burst_strb_gen.sv
// rtl/burst_strb_gen.sv - combinational byte-lane strobe for one beat
//   addr_lo_i : beat address modulo bus width
//   esize_i   : log2 bytes moved by this beat (<= BUS_LOG2)
//   strb_o    : lanes from addr_lo_i up to the end of the esize-aligned slot
module burst_strb_gen #(
  parameter int unsigned BUS_LOG2 = 4
) (
  input  logic [BUS_LOG2-1:0]      addr_lo_i,
  input  logic [2:0]               esize_i,
  output logic [(1<<BUS_LOG2)-1:0] strb_o
);

  localparam int unsigned STRB_W = 1 << BUS_LOG2;

  logic [BUS_LOG2-1:0] span;
  logic [BUS_LOG2-1:0] lane_lo;
  logic [BUS_LOG2-1:0] lane_hi;
  logic [BUS_LOG2-1:0] lane;

  always_comb begin
    span    = BUS_LOG2'((1 << esize_i) - 1);
    lane_lo = addr_lo_i;
    // Aligned slot start plus slot size never exceeds the bus, so no wrap.
    lane_hi = (addr_lo_i & ~span) + span;
    strb_o  = '0;
    lane    = '0;
    for (int i = 0; i < STRB_W; i++) begin
      lane      = BUS_LOG2'(i);
      strb_o[i] = (lane >= lane_lo) && (lane <= lane_hi);
    end
  end

endmodule

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - AXI-style burst command to beat address/strobe sequencer
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       : command handshake (ready only when idle)
//   cmd_addr_i/len_i/size_i/burst_i : burst command fields
//   beat_valid_o/beat_ready_i     : beat handshake
//   beat_addr_o/strb_o/last_o     : per-beat byte address, lanes, final flag
//   cmd_err_o                     : one-cycle pulse when a command is rejected
module burst_addr_gen
  import burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned BUS_LOG2 = 4,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [ADDR_W-1:0]        cmd_addr_i,
  input  logic [LEN_W-1:0]         cmd_len_i,
  input  logic [2:0]               cmd_size_i,
  input  logic [1:0]               cmd_burst_i,
  output logic                     beat_valid_o,
  input  logic                     beat_ready_i,
  output logic [ADDR_W-1:0]        beat_addr_o,
  output logic [(1<<BUS_LOG2)-1:0] beat_strb_o,
  output logic                     beat_last_o,
  output logic                     cmd_err_o
);

  localparam int unsigned STRB_W   = 1 << BUS_LOG2;
  localparam int unsigned CNT_W    = LEN_W + 8;
  localparam logic [2:0]  BUS_SIZE = 3'(BUS_LOG2);

  state_t              state_q,   state_d;
  logic                ready_q,   ready_d;
  logic                err_q,     err_d;
  logic                valid_q,   valid_d;
  logic                last_q,    last_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [ADDR_W-1:0]   start_q,   start_d;
  logic [ADDR_W-1:0]   base_q,    base_d;
  logic [ADDR_W-1:0]   mask_q,    mask_d;
  burst_t              burst_q,   burst_d;
  logic [2:0]          esize_q,   esize_d;
  logic [7:0]          sub_q,     sub_d;
  logic [7:0]          sub_max_q, sub_max_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [CNT_W-1:0]    tot_m1_q,  tot_m1_d;

  // Command decode, evaluated on the command inputs at acceptance.
  logic [2:0]        c_esize;
  logic [2:0]        c_split;
  calc_t             c_beats;
  logic [CNT_W-1:0]  c_tot_m1;
  logic [ADDR_W-1:0] c_mask;
  logic [ADDR_W-1:0] c_base;
  logic              c_wrap_len_ok;
  logic              c_illegal;
  burst_t            c_burst;

  always_comb begin
    c_burst       = burst_t'(cmd_burst_i);
    c_esize       = (cmd_size_i < BUS_SIZE) ? cmd_size_i : BUS_SIZE;
    c_split       = cmd_size_i - c_esize;
    c_beats       = calc_t'(cmd_len_i) + calc_t'(1);
    c_tot_m1      = CNT_W'(c_beats << c_split) - CNT_W'(1);
    c_mask        = ADDR_W'((c_beats << cmd_size_i) - calc_t'(1));
    c_base        = ADDR_W'(align(calc_t'(cmd_addr_i), cmd_size_i));
    c_wrap_len_ok = (c_beats == calc_t'(2)) || (c_beats == calc_t'(4)) ||
                    (c_beats == calc_t'(8)) || (c_beats == calc_t'(16));
    c_illegal     = 1'b0;
    case (c_burst)
      BURST_RSVD: c_illegal = 1'b1;
      BURST_WRAP: c_illegal = !c_wrap_len_ok || (cmd_addr_i != c_base);
      BURST_INCR: c_illegal = page_cross(calc_t'(cmd_addr_i), calc_t'(cmd_len_i),
                                         cmd_size_i, ADDR_W);
      default:    c_illegal = 1'b0;
    endcase
  end

  // Address of the following beat.
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] nxt_addr;
  logic [7:0]        sub_nxt;

  always_comb begin
    step     = ADDR_W'(1) << esize_q;
    sub_nxt  = (sub_q == sub_max_q) ? 8'd0 : sub_q + 8'd1;
    nxt_addr = addr_q;
    case (burst_q)
      BURST_INCR: nxt_addr = (addr_q & ~(step - ADDR_W'(1))) + step;
      BURST_WRAP: nxt_addr = (start_q & ~mask_q) | ((addr_q + step) & mask_q);
      // A non-split FIXED burst repeats the raw (possibly unaligned) address.
      default:    nxt_addr = (sub_max_q == 8'd0) ? addr_q
                                                 : base_q + (ADDR_W'(sub_nxt) << esize_q);
    endcase
  end

  logic             accept;
  logic             beat_hs;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    err_d     = 1'b0;
    valid_d   = valid_q;
    last_d    = last_q;
    addr_d    = addr_q;
    start_d   = start_q;
    base_d    = base_q;
    mask_d    = mask_q;
    burst_d   = burst_q;
    esize_d   = esize_q;
    sub_d     = sub_q;
    sub_max_d = sub_max_q;
    cnt_d     = cnt_q;
    tot_m1_d  = tot_m1_q;
    accept    = cmd_valid_i & ready_q;
    beat_hs   = valid_q & beat_ready_i;
    cnt_nxt   = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        // Ready is registered: it comes up one edge after reset release
        // and one edge after a rejected command.
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          if (c_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d   = ST_RUN;
            valid_d   = 1'b1;
            last_d    = (c_tot_m1 == '0);
            addr_d    = (c_burst == BURST_FIXED && c_split != 3'd0) ? c_base : cmd_addr_i;
            start_d   = cmd_addr_i;
            base_d    = c_base;
            mask_d    = c_mask;
            burst_d   = c_burst;
            esize_d   = c_esize;
            sub_d     = 8'd0;
            sub_max_d = 8'((1 << c_split) - 1);
            cnt_d     = '0;
            tot_m1_d  = c_tot_m1;
          end
        end
      end
      ST_RUN: begin
        if (beat_hs) begin
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
          end else begin
            cnt_d  = cnt_nxt;
            last_d = (cnt_nxt == tot_m1_q);
            addr_d = nxt_addr;
            sub_d  = sub_nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      start_q   <= '0;
      base_q    <= '0;
      mask_q    <= '0;
      burst_q   <= BURST_FIXED;
      esize_q   <= '0;
      sub_q     <= '0;
      sub_max_q <= '0;
      cnt_q     <= '0;
      tot_m1_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
      burst_q   <= burst_d;
      esize_q   <= esize_d;
      sub_q     <= sub_d;
      sub_max_q <= sub_max_d;
      cnt_q     <= cnt_d;
      tot_m1_q  <= tot_m1_d;
    end
  end

  logic [STRB_W-1:0] strb_raw;

  burst_strb_gen #(
    .BUS_LOG2 (BUS_LOG2)
  ) u_strb (
    .addr_lo_i (addr_q[BUS_LOG2-1:0]),
    .esize_i   (esize_q),
    .strb_o    (strb_raw)
  );

  assign cmd_ready_o  = ready_q;
  assign cmd_err_o    = err_q;
  assign beat_valid_o = valid_q;
  assign beat_last_o  = last_q;
  assign beat_addr_o  = addr_q;
  // Strobes are only meaningful with a valid beat; forced low otherwise.
  assign beat_strb_o  = valid_q ? strb_raw : '0;

endmodule

// File: tb/tb_burst_addr_gen.sv
// tb/tb_burst_addr_gen.sv - directed-vector bench for burst_addr_gen
module tb_burst_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [11:0] beat_addr;
  logic [15:0] beat_strb;
  logic        beat_last;
  logic        cmd_err;

  logic        c16_valid = 1'b0;
  logic        c16_ready;
  logic [15:0] c16_addr = '0;
  logic [7:0]  c16_len = '0;
  logic [2:0]  c16_size = '0;
  logic [1:0]  c16_burst = '0;
  logic        b16_valid;
  logic [15:0] b16_addr;
  logic [15:0] b16_strb;
  logic        b16_last;
  logic        c16_err;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_addr [8];
  logic [15:0] exp_strb [8];

  always #5 clk = ~clk;

  burst_addr_gen dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size), .cmd_burst_i(cmd_burst),
    .beat_valid_o(beat_valid), .beat_ready_i(beat_ready),
    .beat_addr_o(beat_addr), .beat_strb_o(beat_strb), .beat_last_o(beat_last),
    .cmd_err_o(cmd_err)
  );

  burst_addr_gen #(.ADDR_W(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(c16_valid), .cmd_ready_o(c16_ready),
    .cmd_addr_i(c16_addr), .cmd_len_i(c16_len), .cmd_size_i(c16_size), .cmd_burst_i(c16_burst),
    .beat_valid_o(b16_valid), .beat_ready_i(1'b1),
    .beat_addr_o(b16_addr), .beat_strb_o(b16_strb), .beat_last_o(b16_last),
    .cmd_err_o(c16_err)
  );

  // Offer a command at a falling edge; returns at the falling edge after acceptance.
  task automatic send_cmd(input logic [11:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Check beats first..n-1 with beat_ready high, then the idle cycle after.
  task automatic collect(input string name, input int first, input int n);
    for (int i = first; i < n; i++) begin
      vectors++;
      if (beat_valid !== 1'b1 || beat_addr !== exp_addr[i] || beat_strb !== exp_strb[i] ||
          beat_last !== (i == n - 1)) begin
        miscompares++;
        $display("FAIL %s beat%0d: got v=%b a=%h s=%h l=%b want v=1 a=%h s=%h l=%b",
                 name, i, beat_valid, beat_addr, beat_strb, beat_last,
                 exp_addr[i], exp_strb[i], (i == n - 1));
      end
      @(negedge clk);
    end
    vectors++;
    if (beat_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s end: got valid=%b ready=%b want valid=0 ready=1",
               name, beat_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({beat_valid, beat_last, cmd_err, cmd_ready} !== 4'b0 || beat_addr !== 12'h0 ||
        beat_strb !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b l=%b e=%b r=%b a=%h s=%h want all 0",
               beat_valid, beat_last, cmd_err, cmd_ready, beat_addr, beat_strb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 0", cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_rise: got %b want 1", cmd_ready);
    end
  endtask

  task automatic load_incr_104();
    exp_addr[0] = 12'h104; exp_strb[0] = 16'h00F0;
    exp_addr[1] = 12'h108; exp_strb[1] = 16'h0F00;
    exp_addr[2] = 12'h10C; exp_strb[2] = 16'hF000;
    exp_addr[3] = 12'h110; exp_strb[3] = 16'h000F;
  endtask

  task automatic test_incr();
    load_incr_104();
    send_cmd(12'h104, 8'd3, 3'd2, 2'b01);
    collect("incr", 0, 4);
  endtask

  task automatic test_wrap();
    exp_addr[0] = 12'h038; exp_strb[0] = 16'hFF00;
    exp_addr[1] = 12'h020; exp_strb[1] = 16'h00FF;
    exp_addr[2] = 12'h028; exp_strb[2] = 16'hFF00;
    exp_addr[3] = 12'h030; exp_strb[3] = 16'h00FF;
    send_cmd(12'h038, 8'd3, 3'd3, 2'b10);
    collect("wrap", 0, 4);
  endtask

  task automatic test_split();
    for (int i = 0; i < 4; i++) exp_strb[i] = 16'hFFFF;
    exp_addr[0] = 12'h200; exp_addr[1] = 12'h210; exp_addr[2] = 12'h220; exp_addr[3] = 12'h230;
    send_cmd(12'h200, 8'd1, 3'd5, 2'b01);
    collect("split_incr", 0, 4);
    exp_addr[2] = 12'h200; exp_addr[3] = 12'h210;
    send_cmd(12'h200, 8'd1, 3'd5, 2'b00);
    collect("split_fixed", 0, 4);
  endtask

  task automatic test_unaligned();
    exp_addr[0] = 12'h013; exp_strb[0] = 16'h0008;
    exp_addr[1] = 12'h014; exp_strb[1] = 16'h00F0;
    send_cmd(12'h013, 8'd1, 3'd2, 2'b01);
    collect("unaligned", 0, 2);
  endtask

  task automatic test_illegal(input string name, input logic [11:0] a, input logic [7:0] l,
                              input logic [2:0] s, input logic [1:0] b);
    int vcount;
    send_cmd(a, l, s, b);
    vectors++;
    if (cmd_err !== 1'b1 || cmd_ready !== 1'b0 || beat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse: got err=%b ready=%b valid=%b want 1 0 0",
               name, cmd_err, cmd_ready, beat_valid);
    end
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (beat_valid === 1'b1 || cmd_err !== 1'b0) vcount++;
    end
    vectors++;
    if (vcount != 0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after: got bad_cycles=%0d ready=%b want 0 1", name, vcount, cmd_ready);
    end
  endtask

  task automatic test_page_cross_16();
    c16_addr = 16'h0FF0; c16_len = 8'd1; c16_size = 3'd4; c16_burst = 2'b01;
    vectors++;
    if (c16_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL page16_ready: got %b want 1", c16_ready);
    end
    c16_valid = 1'b1;
    @(negedge clk);
    c16_valid = 1'b0;
    vectors++;
    if (c16_err !== 1'b1 || c16_ready !== 1'b0 || b16_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL page16_pulse: got err=%b ready=%b valid=%b want 1 0 0",
               c16_err, c16_ready, b16_valid);
    end
    @(negedge clk);
    vectors++;
    if (c16_err !== 1'b0 || c16_ready !== 1'b1 || b16_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL page16_after: got err=%b ready=%b valid=%b want 0 1 0",
               c16_err, c16_ready, b16_valid);
    end
  endtask

  task automatic test_backpressure();
    load_incr_104();
    send_cmd(12'h104, 8'd3, 3'd2, 2'b01);
    collect_one("bp", 0);
    @(negedge clk);
    beat_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (beat_valid !== 1'b1 || beat_addr !== 12'h108 || beat_strb !== 16'h0F00 ||
          beat_last !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b a=%h s=%h l=%b want 1 108 0f00 0",
                 k, beat_valid, beat_addr, beat_strb, beat_last);
      end
      if (k < 3) @(negedge clk);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    collect("bp", 2, 4);
  endtask

  task automatic collect_one(input string name, input int i);
    vectors++;
    if (beat_valid !== 1'b1 || beat_addr !== exp_addr[i] || beat_strb !== exp_strb[i]) begin
      miscompares++;
      $display("FAIL %s beat%0d: got v=%b a=%h s=%h want 1 %h %h",
               name, i, beat_valid, beat_addr, beat_strb, exp_addr[i], exp_strb[i]);
    end
  endtask

  task automatic test_reset_mid_burst();
    load_incr_104();
    send_cmd(12'h104, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({beat_valid, beat_last, cmd_err, cmd_ready} !== 4'b0 || beat_addr !== 12'h0 ||
        beat_strb !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got v=%b l=%b e=%b r=%b a=%h s=%h want all 0",
               beat_valid, beat_last, cmd_err, cmd_ready, beat_addr, beat_strb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0 || beat_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_release: got ready=%b valid=%b want 0 0", cmd_ready, beat_valid);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_ready: got %b want 1", cmd_ready);
    end
    test_wrap();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_split();
    test_unaligned();
    test_illegal("rsvd", 12'h100, 8'd0, 3'd2, 2'b11);
    test_illegal("wrap_len3", 12'h040, 8'd2, 3'd2, 2'b10);
    test_illegal("wrap_unaligned", 12'h034, 8'd3, 3'd3, 2'b10);
    test_page_cross_16();
    test_backpressure();
    test_reset_mid_burst();
    test_incr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
